// File: rtl/riscv_dmem_if_if.sv
// LSU-side and bus-side port bundles for riscv_dmem_if.
// dmem_size encoding: 0=BYTE 1=HWORD 2=WORD 3=DWORD 4=UNDEF_SIZE.
interface riscv_dmem_lsu_if #(
   parameter int XLEN = 32
);
   typedef logic [2:0] biu_size_t;

   logic            dmem_req;
   logic [XLEN-1:0] dmem_adr;
   logic [XLEN-1:0] dmem_d;
   logic            dmem_we;
   biu_size_t       dmem_size;
   logic            dmem_kill;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_q;
   logic            dmem_misaligned;
   logic            dmem_page_fault;
   logic            dmem_err;

   modport master (
      output dmem_req, dmem_adr, dmem_d, dmem_we, dmem_size, dmem_kill,
      input  dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault, dmem_err
   );

   modport slave (
      input  dmem_req, dmem_adr, dmem_d, dmem_we, dmem_size, dmem_kill,
      output dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault, dmem_err
   );
endinterface

interface riscv_dmem_bus_if #(
   parameter int XLEN = 32
);
   logic              bus_req;
   logic [XLEN-1:0]   bus_adr;
   logic              bus_we;
   logic [XLEN/8-1:0] bus_be;
   logic [XLEN-1:0]   bus_d;
   logic              bus_ack;
   logic              bus_err;
   logic [XLEN-1:0]   bus_q;

   modport master (
      output bus_req, bus_adr, bus_we, bus_be, bus_d,
      input  bus_ack, bus_err, bus_q
   );

   modport slave (
      input  bus_req, bus_adr, bus_we, bus_be, bus_d,
      output bus_ack, bus_err, bus_q
   );
endinterface

// File: rtl/riscv_dmem_if.sv
// Single-outstanding bridge from the load/store unit to an ack-based data bus.
// Optional bus watchdog is enabled by defining RISCV_DMEM_TIMEOUT_EN.
module riscv_dmem_if #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   riscv_dmem_lsu_if.slave  lsu,
   riscv_dmem_bus_if.master bus
);
   localparam int BEW  = XLEN / 8;
   localparam int OFFW = $clog2(BEW);

   localparam logic [2:0] SZ_BYTE  = 3'd0;
   localparam logic [2:0] SZ_HWORD = 3'd1;
   localparam logic [2:0] SZ_WORD  = 3'd2;
   localparam logic [2:0] SZ_DWORD = 3'd3;

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

   state_t          state_q;
   logic            bus_req_q;
   logic            bus_we_q;
   logic [XLEN-1:0] bus_adr_q;
   logic [XLEN-1:0] bus_d_q;
   logic [BEW-1:0]  bus_be_q;
   logic            ack_q;
   logic            mis_q;
   logic            err_q;
   logic [XLEN-1:0] q_q;

   logic [OFFW-1:0] off;
   logic [2:0]      size;
   logic            aligned_d;
   logic [BEW-1:0]  be_d;
   logic            done;
   logic            expired;

   assign off  = lsu.dmem_adr[OFFW-1:0];
   assign size = lsu.dmem_size;
   assign done = bus.bus_ack | bus.bus_err;

   always_comb begin
      aligned_d = 1'b0;
      be_d      = '0;
      case (size)
         SZ_BYTE: begin
            aligned_d = 1'b1;
            be_d      = BEW'(1) << off;
         end
         SZ_HWORD: begin
            aligned_d = ~lsu.dmem_adr[0];
            be_d      = BEW'(3) << off;
         end
         SZ_WORD: begin
            aligned_d = (lsu.dmem_adr[1:0] == 2'b00);
            be_d      = BEW'(15) << off;
         end
         SZ_DWORD: begin
            aligned_d = (XLEN == 64) && (lsu.dmem_adr[2:0] == 3'b000);
            be_d      = '1;
         end
         default: ;
      endcase
   end

`ifdef RISCV_DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   assign expired = (cnt_q == CNT_W'(TIMEOUT));

   // Restarts on every entry to BUSY (from IDLE) and to DRAIN (kill in BUSY).
   always_ff @(posedge clk) begin
      if (rst || state_q == IDLE || state_q == RESP || (state_q == BUSY && lsu.dmem_kill))
         cnt_q <= '0;
      else if (!expired)
         cnt_q <= cnt_q + 1'b1;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bus_req_q <= 1'b0;
         bus_we_q  <= 1'b0;
         bus_adr_q <= '0;
         bus_d_q   <= '0;
         bus_be_q  <= '0;
         ack_q     <= 1'b0;
         mis_q     <= 1'b0;
         err_q     <= 1'b0;
         q_q       <= '0;
      end else begin
         // Status and read data are only meaningful in the single RESP cycle.
         ack_q <= 1'b0;
         mis_q <= 1'b0;
         err_q <= 1'b0;
         q_q   <= '0;
         case (state_q)
            IDLE: begin
               if (lsu.dmem_req && !lsu.dmem_kill) begin
                  if (aligned_d) begin
                     state_q   <= BUSY;
                     bus_req_q <= 1'b1;
                     bus_adr_q <= {lsu.dmem_adr[XLEN-1:OFFW], OFFW'(0)};
                     bus_we_q  <= lsu.dmem_we;
                     bus_be_q  <= be_d;
                     bus_d_q   <= lsu.dmem_d;
                  end else begin
                     state_q <= RESP;
                     ack_q   <= 1'b1;
                     mis_q   <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (done) begin
                  bus_req_q <= 1'b0;
                  if (lsu.dmem_kill) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= RESP;
                     ack_q   <= 1'b1;
                     err_q   <= bus.bus_err;
                     q_q     <= bus_we_q ? '0 : bus.bus_q;
                  end
               end else if (expired) begin
                  bus_req_q <= 1'b0;
                  if (lsu.dmem_kill) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= RESP;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                  end
               end else if (lsu.dmem_kill) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (done || expired) begin
                  bus_req_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.bus_req          = bus_req_q;
   assign bus.bus_adr          = bus_adr_q;
   assign bus.bus_we           = bus_we_q;
   assign bus.bus_be           = bus_be_q;
   assign bus.bus_d            = bus_d_q;
   assign lsu.dmem_ack         = ack_q;
   assign lsu.dmem_q           = q_q;
   assign lsu.dmem_misaligned  = mis_q;
   assign lsu.dmem_err         = err_q;
   assign lsu.dmem_page_fault  = 1'b0;
endmodule

// File: tb/tb_riscv_dmem_if.sv
// Directed bench for riscv_dmem_if (XLEN=32, TIMEOUT=8); the watchdog case
// runs only when RISCV_DMEM_TIMEOUT_EN is defined.
module tb_riscv_dmem_if;
   localparam int XLEN = 32;

   localparam logic [2:0] SZ_BYTE  = 3'd0;
   localparam logic [2:0] SZ_HWORD = 3'd1;
   localparam logic [2:0] SZ_WORD  = 3'd2;
   localparam logic [2:0] SZ_DWORD = 3'd3;
   localparam logic [2:0] SZ_UNDEF = 3'd4;

   typedef struct {
      logic [2:0]  sz;
      logic [31:0] adr;
      logic        mis;
      logic [3:0]  be;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_ack = 0;
   vec_t tv[6];

   riscv_dmem_lsu_if #(.XLEN(XLEN)) lsu ();
   riscv_dmem_bus_if #(.XLEN(XLEN)) bus ();

   riscv_dmem_if #(.XLEN(XLEN), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .lsu (lsu),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (lsu.dmem_ack) n_ack++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic req(input logic we, input logic [2:0] sz, input logic [31:0] adr, input logic [31:0] d);
      lsu.dmem_req  = 1'b1;
      lsu.dmem_we   = we;
      lsu.dmem_size = sz;
      lsu.dmem_adr  = adr;
      lsu.dmem_d    = d;
   endtask

   task automatic idle_lsu();
      lsu.dmem_req  = 1'b0;
      lsu.dmem_kill = 1'b0;
   endtask

   task automatic reply(input logic a, input logic e, input logic [31:0] q);
      bus.bus_ack = a;
      bus.bus_err = e;
      bus.bus_q   = q;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int k;
      int a0;
      tv[0] = '{SZ_BYTE,  32'h201, 1'b0, 4'b0010};
      tv[1] = '{SZ_HWORD, 32'h102, 1'b0, 4'b1100};
      tv[2] = '{SZ_HWORD, 32'h101, 1'b1, 4'b0000};
      tv[3] = '{SZ_WORD,  32'h102, 1'b1, 4'b0000};
      tv[4] = '{SZ_UNDEF, 32'h100, 1'b1, 4'b0000};
      tv[5] = '{SZ_DWORD, 32'h100, 1'b1, 4'b0000};

      rst = 1'b1;
      idle_lsu();
      lsu.dmem_we   = 1'b0;
      lsu.dmem_size = SZ_WORD;
      lsu.dmem_adr  = '0;
      lsu.dmem_d    = '0;
      reply(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      chk("rst_ctl", 64'({bus.bus_req, lsu.dmem_ack, lsu.dmem_misaligned, lsu.dmem_err,
                          bus.bus_we, lsu.dmem_page_fault}), 64'(0));
      chk("rst_data", 64'({lsu.dmem_q, bus.bus_adr}), 64'(0));
      chk("rst_bus", 64'({bus.bus_d, bus.bus_be}), 64'(0));
      rst = 1'b0;
      tick();

      // LW 0x100, bus_ack three cycles after the request
      a0 = n_ack;
      req(1'b0, SZ_WORD, 32'h100, 32'h0);
      tick();
      chk("lw_req", 64'({bus.bus_req, bus.bus_we, bus.bus_be}), 64'(6'b10_1111));
      chk("lw_adr", 64'(bus.bus_adr), 64'(32'h100));
      tick();
      tick();
      chk("lw_hold", 64'({bus.bus_req, lsu.dmem_ack, bus.bus_adr}), {30'd0, 2'b10, 32'h100});
      reply(1'b1, 1'b0, 32'hDEADBEEF);
      tick();
      chk("lw_resp", 64'({lsu.dmem_ack, bus.bus_req, lsu.dmem_err}), 64'(3'b100));
      chk("lw_q", 64'(lsu.dmem_q), 64'(32'hDEADBEEF));
      reply(1'b0, 1'b0, 32'h0);
      idle_lsu();
      tick();
      chk("lw_ack_once", 64'({lsu.dmem_ack, lsu.dmem_q}), 64'(0));
      chk("lw_nack", 64'(n_ack - a0), 64'(1));

      // SB 0x203, bus acks at the earliest cycle
      req(1'b1, SZ_BYTE, 32'h203, 32'hAA000000);
      tick();
      chk("sb_bus", 64'({bus.bus_req, bus.bus_we, bus.bus_be}), 64'(6'b11_1000));
      chk("sb_d", 64'({bus.bus_d, bus.bus_adr}), {32'hAA000000, 32'h200});
      reply(1'b1, 1'b0, 32'h0);
      tick();
      chk("sb_resp", 64'({lsu.dmem_ack, bus.bus_req}), 64'(2'b10));
      reply(1'b0, 1'b0, 32'h0);
      idle_lsu();
      tick();
      chk("sb_idle", 64'({lsu.dmem_ack, bus.bus_req}), 64'(0));

      // Alignment / byte-enable table
      for (int i = 0; i < 6; i++) begin
         req(1'b0, tv[i].sz, tv[i].adr, 32'h0);
         tick();
         if (tv[i].mis) begin
            chk($sformatf("mis_resp%0d", i),
                64'({lsu.dmem_ack, lsu.dmem_misaligned, bus.bus_req}), 64'(3'b110));
         end else begin
            chk($sformatf("al_be%0d", i), 64'({bus.bus_req, bus.bus_be}), 64'({1'b1, tv[i].be}));
            reply(1'b1, 1'b0, 32'h55);
            tick();
            chk($sformatf("al_resp%0d", i),
                64'({lsu.dmem_ack, lsu.dmem_misaligned, bus.bus_req}), 64'(3'b100));
            reply(1'b0, 1'b0, 32'h0);
         end
         idle_lsu();
         tick();
         chk($sformatf("vec_idle%0d", i), 64'({lsu.dmem_ack, lsu.dmem_misaligned}), 64'(0));
      end

      // Kill while BUSY: bus cycle completes silently, then a new request is taken
      a0 = n_ack;
      req(1'b0, SZ_WORD, 32'h300, 32'h0);
      tick();
      chk("kill_acc", 64'(bus.bus_req), 64'(1));
      lsu.dmem_req  = 1'b0;
      lsu.dmem_kill = 1'b1;
      tick();
      lsu.dmem_kill = 1'b0;
      chk("kill_hold", 64'({bus.bus_req, lsu.dmem_ack}), 64'(2'b10));
      tick();
      chk("drain_hold", 64'({bus.bus_req, lsu.dmem_ack}), 64'(2'b10));
      reply(1'b1, 1'b0, 32'h77);
      tick();
      chk("drain_done", 64'({bus.bus_req, lsu.dmem_ack, lsu.dmem_q}), 64'(0));
      reply(1'b0, 1'b0, 32'h0);
      tick();
      chk("drain_nack", 64'(n_ack - a0), 64'(0));
      req(1'b0, SZ_WORD, 32'h400, 32'h0);
      tick();
      chk("after_kill", 64'({bus.bus_req, bus.bus_adr}), {31'd0, 1'b1, 32'h400});
      reply(1'b1, 1'b0, 32'h1234);
      tick();
      chk("after_kill_q", 64'({lsu.dmem_ack, lsu.dmem_q}), {31'd0, 1'b1, 32'h1234});
      reply(1'b0, 1'b0, 32'h0);
      idle_lsu();
      tick();

      // Bus error, and ack+err together
      req(1'b0, SZ_WORD, 32'h140, 32'h0);
      tick();
      reply(1'b0, 1'b1, 32'h0);
      tick();
      chk("berr", 64'({lsu.dmem_ack, lsu.dmem_err, lsu.dmem_misaligned}), 64'(3'b110));
      reply(1'b0, 1'b0, 32'h0);
      idle_lsu();
      tick();
      chk("berr_clr", 64'({lsu.dmem_ack, lsu.dmem_err}), 64'(0));
      req(1'b1, SZ_WORD, 32'h144, 32'h11);
      tick();
      reply(1'b1, 1'b1, 32'h0);
      tick();
      chk("ack_err", 64'({lsu.dmem_ack, lsu.dmem_err}), 64'(2'b11));
      reply(1'b0, 1'b0, 32'h0);
      idle_lsu();
      tick();

      // Request with kill in IDLE is ignored
      req(1'b0, SZ_WORD, 32'h180, 32'h0);
      lsu.dmem_kill = 1'b1;
      tick();
      chk("idle_kill", 64'({bus.bus_req, lsu.dmem_ack}), 64'(0));
      idle_lsu();
      tick();

      // Reset mid-BUSY, then a stale bus_ack
      req(1'b0, SZ_WORD, 32'h1C0, 32'h0);
      tick();
      chk("pre_rst", 64'(bus.bus_req), 64'(1));
      rst = 1'b1;
      tick();
      chk("rst_busy", 64'({bus.bus_req, lsu.dmem_ack, lsu.dmem_err, bus.bus_we, bus.bus_be}), 64'(0));
      chk("rst_busy_adr", 64'({bus.bus_adr, lsu.dmem_q}), 64'(0));
      rst = 1'b0;
      idle_lsu();
      reply(1'b1, 1'b0, 32'h99);
      tick();
      chk("stale", 64'({lsu.dmem_ack, bus.bus_req, lsu.dmem_q}), 64'(0));
      reply(1'b0, 1'b0, 32'h0);
      tick();

`ifdef RISCV_DMEM_TIMEOUT_EN
      // Bus never responds: watchdog fires after TIMEOUT waiting cycles
      a0 = n_ack;
      req(1'b0, SZ_WORD, 32'h500, 32'h0);
      tick();
      k = 0;
      while (!lsu.dmem_ack && k < 20) begin
         tick();
         k++;
      end
      chk("to_cycles", 64'(k), 64'(9));
      chk("to_resp", 64'({lsu.dmem_ack, lsu.dmem_err, bus.bus_req}), 64'(3'b110));
      chk("to_q", 64'(lsu.dmem_q), 64'(0));
      idle_lsu();
      tick();
      reply(1'b1, 1'b0, 32'hBAD);
      tick();
      chk("to_late", 64'({lsu.dmem_ack, bus.bus_req, lsu.dmem_q}), 64'(0));
      reply(1'b0, 1'b0, 32'h0);
      tick();
      chk("to_nack", 64'(n_ack - a0), 64'(1));
`else
      k = 0;
      a0 = 0;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
